rf_writeback: RTL and testbench

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/rf_writeback_if.sv | 40 ++++
 rtl/rf_writeback.sv | 141 ++++++++++++++
 tb/tb_rf_writeback.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_if.sv
// rf_writeback_if: the ALU/LSU result, load-issue, hazard-query and
// register-file write bundle of rf_writeback. The design takes the slave
// modport and the producer side takes the master modport.
interface rf_writeback_if #(
   parameter int DATA_WIDTH = 32
);
   logic                    alu_valid_i;
   logic                    alu_ready_o;
   logic [4:0]              alu_rd_i;
   logic [DATA_WIDTH-1:0]   alu_data_i;
   logic                    lsu_valid_i;
   logic [4:0]              lsu_rd_i;
   logic [DATA_WIDTH-1:0]   lsu_data_i;
   logic [1:0]              lsu_size_i;
   logic                    lsu_unsigned_i;
   logic [1:0]              lsu_offset_i;
   logic                    lsu_issue_i;
   logic [4:0]              lsu_issue_rd_i;
   logic [4:0]              rs1_q_i;
   logic [4:0]              rs2_q_i;
   logic                    hazard_o;
   logic [4:0]              rd_o;
   logic [DATA_WIDTH-1:0]   wdata_o;
   logic                    wen_o;
   logic [DATA_WIDTH/8-1:0] wstrb_o;

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_size_i, lsu_unsigned_i, lsu_offset_i,
      input  lsu_issue_i, lsu_issue_rd_i, rs1_q_i, rs2_q_i,
      output alu_ready_o, hazard_o, rd_o, wdata_o, wen_o, wstrb_o
   );

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      output lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_size_i, lsu_unsigned_i, lsu_offset_i,
      output lsu_issue_i, lsu_issue_rd_i, rs1_q_i, rs2_q_i,
      input  alu_ready_o, hazard_o, rd_o, wdata_o, wen_o, wstrb_o
   );
endinterface

// File: rtl/rf_writeback.sv
// rf_writeback: register-file writeback arbiter.
// Merges ALU results and load returns into one registered write port.
// Load returns always win. An ALU result that collides with a load is
// parked in a one-entry skid buffer and written on the next load-free cycle.
// Optional pending-load scoreboard with decode hazard query, enabled by
// defining RF_WB_SCOREBOARD_EN. Without it hazard_o is tied to 0.
module rf_writeback #(
   parameter int DATA_WIDTH = 32,
   parameter int N_REGS     = 32
) (
   input logic           clk,
   input logic           rst_n,
   rf_writeback_if.slave wb
);
   typedef enum logic {EMPTY, FULL} skid_state_t;

   skid_state_t           state, state_nxt;
   logic [4:0]            skid_rd;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  alu_acc;
   logic                  skid_load;
   logic                  sel_vld;
   logic [4:0]            sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] ld_fmt;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic                  ld_sext;

   assign wb.alu_ready_o = (state == EMPTY);
   assign alu_acc        = wb.alu_valid_i && wb.alu_ready_o;

   // Load formatting: pick byte/half lane by offset, then zero/sign extend.
   always_comb begin
      ld_byte = wb.lsu_data_i[{wb.lsu_offset_i, 3'b000} +: 8];
      ld_half = wb.lsu_data_i[{wb.lsu_offset_i[1], 4'b0000} +: 16];
      ld_sext = !wb.lsu_unsigned_i;
      ld_fmt  = wb.lsu_data_i;
      case (wb.lsu_size_i)
         2'b00:   ld_fmt = {{(DATA_WIDTH-8){ld_sext & ld_byte[7]}}, ld_byte};
         2'b01:   ld_fmt = {{(DATA_WIDTH-16){ld_sext & ld_half[15]}}, ld_half};
         default: ld_fmt = wb.lsu_data_i;
      endcase
   end

   // Skid FSM next state; capture only when an accepted ALU result loses to a load.
   always_comb begin
      state_nxt = state;
      skid_load = 1'b0;
      case (state)
         EMPTY: if (alu_acc && wb.lsu_valid_i) begin
            state_nxt = FULL;
            skid_load = 1'b1;
         end
         FULL: if (!wb.lsu_valid_i) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Skid state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   // Skid entry payload; contents are don't-care while EMPTY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_rd   <= '0;
         skid_data <= '0;
      end else if (skid_load) begin
         skid_rd   <= wb.alu_rd_i;
         skid_data <= wb.alu_data_i;
      end
   end

   // Source select: load, then skid entry, then a directly accepted ALU result.
   always_comb begin
      sel_vld  = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      if (wb.lsu_valid_i) begin
         sel_vld  = 1'b1;
         sel_rd   = wb.lsu_rd_i;
         sel_data = ld_fmt;
      end else if (state == FULL) begin
         sel_vld  = 1'b1;
         sel_rd   = skid_rd;
         sel_data = skid_data;
      end else if (alu_acc) begin
         sel_vld  = 1'b1;
         sel_rd   = wb.alu_rd_i;
         sel_data = wb.alu_data_i;
      end
   end

   // Registered write port; address/data hold when idle, x0 writes are suppressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb.rd_o    <= '0;
         wb.wdata_o <= '0;
         wb.wen_o   <= 1'b0;
         wb.wstrb_o <= '0;
      end else if (sel_vld) begin
         wb.rd_o    <= sel_rd;
         wb.wdata_o <= sel_data;
         wb.wen_o   <= (sel_rd != 5'd0);
         wb.wstrb_o <= (sel_rd != 5'd0) ? '1 : '0;
      end else begin
         wb.wen_o   <= 1'b0;
         wb.wstrb_o <= '0;
      end
   end

`ifdef RF_WB_SCOREBOARD_EN
   logic [N_REGS-1:0] pending;
   logic [31:0]       pend_ext;

   // Pending-load bits; a same-cycle issue beats the return, x0 never set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else begin
         for (int i = 0; i < N_REGS; i++) begin
            if (i != 0 && wb.lsu_issue_i && wb.lsu_issue_rd_i == 5'(i))
               pending[i] <= 1'b1;
            else if (wb.lsu_valid_i && wb.lsu_rd_i == 5'(i))
               pending[i] <= 1'b0;
         end
      end
   end

   // Pad to 32 entries so any 5-bit query indexes safely.
   assign pend_ext    = 32'(pending);
   assign wb.hazard_o = (pend_ext[wb.rs1_q_i] && wb.rs1_q_i != 5'd0) ||
                        (pend_ext[wb.rs2_q_i] && wb.rs2_q_i != 5'd0);
`else
   logic unused_sb;
   assign unused_sb   = ^{wb.lsu_issue_i, wb.lsu_issue_rd_i, wb.rs1_q_i, wb.rs2_q_i, N_REGS[0]};
   assign wb.hazard_o = 1'b0;
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed table of single-cycle results plus hand-written
// sequences for skid collisions, scoreboard hazards and reset mid-operation.
module tb_rf_writeback;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rf_writeback_if #(.DATA_WIDTH(32)) ifc ();

   rf_writeback #(.DATA_WIDTH(32), .N_REGS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (ifc.slave)
   );

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldat;
      logic [1:0]  sz;
      logic        un;
      logic [1:0]  off;
      logic        ewen;
      logic [4:0]  erd;
      logic [31:0] ewd;
      logic [3:0]  estb;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                               logic lv, logic [4:0] lrd, logic [31:0] ldat,
                               logic [1:0] sz, logic un, logic [1:0] off,
                               logic ewen, logic [4:0] erd, logic [31:0] ewd, logic [3:0] estb);
      vec_t v;
      v.av = av; v.ard = ard; v.adat = adat;
      v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.sz = sz; v.un = un; v.off = off;
      v.ewen = ewen; v.erd = erd; v.ewd = ewd; v.estb = estb;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      ifc.alu_valid_i    = 1'b0;
      ifc.alu_rd_i       = '0;
      ifc.alu_data_i     = '0;
      ifc.lsu_valid_i    = 1'b0;
      ifc.lsu_rd_i       = '0;
      ifc.lsu_data_i     = '0;
      ifc.lsu_size_i     = 2'b10;
      ifc.lsu_unsigned_i = 1'b0;
      ifc.lsu_offset_i   = '0;
      ifc.lsu_issue_i    = 1'b0;
      ifc.lsu_issue_rd_i = '0;
      ifc.rs1_q_i        = '0;
      ifc.rs2_q_i        = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string nm, input logic wen, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [3:0] stb);
      chk({nm, ".wen"},   32'(ifc.wen_o),   32'(wen));
      chk({nm, ".rd"},    32'(ifc.rd_o),    32'(rd));
      chk({nm, ".wdata"}, ifc.wdata_o,      wd);
      chk({nm, ".wstrb"}, 32'(ifc.wstrb_o), 32'(stb));
   endtask

   initial begin
      //         av  ard    adat          lv  lrd    ldat          sz     un  off    wen rd     wdata         stb
      vecs[0]  = mk(1, 5'd5,  32'h00001234, 0, 5'd0,  32'h0,        2'b10, 0, 2'd0,  1, 5'd5,  32'h00001234, 4'hF);
      vecs[1]  = mk(0, 5'd0,  32'h0,        1, 5'd1,  32'hDEADBEEF, 2'b10, 0, 2'd0,  1, 5'd1,  32'hDEADBEEF, 4'hF);
      vecs[2]  = mk(0, 5'd0,  32'h0,        1, 5'd2,  32'h80FF7F01, 2'b11, 0, 2'd0,  1, 5'd2,  32'h80FF7F01, 4'hF);
      vecs[3]  = mk(0, 5'd0,  32'h0,        1, 5'd6,  32'h80FF7F01, 2'b00, 0, 2'd3,  1, 5'd6,  32'hFFFFFF80, 4'hF);
      vecs[4]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  32'h80FF7F01, 2'b01, 1, 2'd2,  1, 5'd7,  32'h000080FF, 4'hF);
      vecs[5]  = mk(0, 5'd0,  32'h0,        1, 5'd8,  32'h80FF7F01, 2'b00, 0, 2'd0,  1, 5'd8,  32'h00000001, 4'hF);
      vecs[6]  = mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h80FF7F01, 2'b00, 0, 2'd1,  1, 5'd9,  32'h0000007F, 4'hF);
      vecs[7]  = mk(0, 5'd0,  32'h0,        1, 5'd10, 32'h80FF7F01, 2'b00, 1, 2'd2,  1, 5'd10, 32'h000000FF, 4'hF);
      vecs[8]  = mk(0, 5'd0,  32'h0,        1, 5'd11, 32'h80FF7F01, 2'b00, 0, 2'd2,  1, 5'd11, 32'hFFFFFFFF, 4'hF);
      vecs[9]  = mk(0, 5'd0,  32'h0,        1, 5'd12, 32'h80FF7F01, 2'b01, 0, 2'd0,  1, 5'd12, 32'h00007F01, 4'hF);
      vecs[10] = mk(0, 5'd0,  32'h0,        1, 5'd13, 32'h80FF7F01, 2'b01, 0, 2'd3,  1, 5'd13, 32'hFFFF80FF, 4'hF);
      vecs[11] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        2'b10, 0, 2'd0,  0, 5'd13, 32'hFFFF80FF, 4'h0);
      vecs[12] = mk(1, 5'd0,  32'h0000CAFE, 0, 5'd0,  32'h0,        2'b10, 0, 2'd0,  0, 5'd0,  32'h0000CAFE, 4'h0);
      vecs[13] = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h00001111, 2'b10, 0, 2'd0,  0, 5'd0,  32'h00001111, 4'h0);
      vecs[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        2'b10, 0, 2'd0,  0, 5'd0,  32'h00001111, 4'h0);
      vecs[15] = mk(1, 5'd31, 32'hFFFFFFFF, 0, 5'd0,  32'h0,        2'b10, 0, 2'd0,  1, 5'd31, 32'hFFFFFFFF, 4'hF);
      vecs[16] = mk(0, 5'd0,  32'h0,        1, 5'd3,  32'h80FF7F01, 2'b01, 1, 2'd1,  1, 5'd3,  32'h00007F01, 4'hF);

      idle();
      #1;
      chk_wr("rst", 0, 5'd0, 32'h0, 4'h0);
      chk("rst.ready",  32'(ifc.alu_ready_o), 32'd1);
      chk("rst.hazard", 32'(ifc.hazard_o),    32'd0);
      #13 rst_n = 1'b1;
      step();

      // Table: each record is one cycle of input, checked after the next edge.
      for (int i = 0; i < 17; i++) begin
         ifc.alu_valid_i    = vecs[i].av;
         ifc.alu_rd_i       = vecs[i].ard;
         ifc.alu_data_i     = vecs[i].adat;
         ifc.lsu_valid_i    = vecs[i].lv;
         ifc.lsu_rd_i       = vecs[i].lrd;
         ifc.lsu_data_i     = vecs[i].ldat;
         ifc.lsu_size_i     = vecs[i].sz;
         ifc.lsu_unsigned_i = vecs[i].un;
         ifc.lsu_offset_i   = vecs[i].off;
         step();
         chk_wr($sformatf("vec%0d", i), vecs[i].ewen, vecs[i].erd, vecs[i].ewd, vecs[i].estb);
         chk($sformatf("vec%0d.ready", i), 32'(ifc.alu_ready_o), 32'd1);
      end
      idle();
      step();

      // Collision: load wins, ALU parked, next ALU held off until skid drains.
      ifc.alu_valid_i = 1'b1; ifc.alu_rd_i = 5'd3; ifc.alu_data_i = 32'hAA;
      ifc.lsu_valid_i = 1'b1; ifc.lsu_rd_i = 5'd4; ifc.lsu_data_i = 32'h55;
      #1 chk("col.ready0", 32'(ifc.alu_ready_o), 32'd1);
      step();
      chk_wr("col.c1", 1, 5'd4, 32'h55, 4'hF);
      chk("col.c1.ready", 32'(ifc.alu_ready_o), 32'd0);
      ifc.lsu_valid_i = 1'b0;
      ifc.alu_rd_i = 5'd9; ifc.alu_data_i = 32'hBB;
      step();
      chk_wr("col.c2", 1, 5'd3, 32'hAA, 4'hF);
      chk("col.c2.ready", 32'(ifc.alu_ready_o), 32'd1);
      step();
      chk_wr("col.c3", 1, 5'd9, 32'hBB, 4'hF);
      idle();
      step();

      // Skid holds while loads keep arriving.
      ifc.alu_valid_i = 1'b1; ifc.alu_rd_i = 5'd3; ifc.alu_data_i = 32'hAA;
      ifc.lsu_valid_i = 1'b1; ifc.lsu_rd_i = 5'd4; ifc.lsu_data_i = 32'h55;
      step();
      ifc.alu_rd_i = 5'd20; ifc.alu_data_i = 32'hEE;
      ifc.lsu_rd_i = 5'd5; ifc.lsu_data_i = 32'h66;
      step();
      chk_wr("hold.c2", 1, 5'd5, 32'h66, 4'hF);
      chk("hold.c2.ready", 32'(ifc.alu_ready_o), 32'd0);
      idle();
      step();
      chk_wr("hold.c3", 1, 5'd3, 32'hAA, 4'hF);
      step();
      chk_wr("hold.c4", 0, 5'd3, 32'hAA, 4'h0);

      // Scoreboard / hazard query.
      ifc.lsu_issue_i = 1'b1; ifc.lsu_issue_rd_i = 5'd7;
      step();
      ifc.lsu_issue_i = 1'b0;
      ifc.rs1_q_i = 5'd7;
      #1;
`ifdef RF_WB_SCOREBOARD_EN
      chk("sb.rs1", 32'(ifc.hazard_o), 32'd1);
      ifc.lsu_valid_i = 1'b1; ifc.lsu_rd_i = 5'd7; ifc.lsu_data_i = 32'h1;
      ifc.lsu_issue_i = 1'b1; ifc.lsu_issue_rd_i = 5'd7;
      step();
      chk("sb.setwins", 32'(ifc.hazard_o), 32'd1);
      ifc.lsu_issue_i = 1'b0;
      step();
      chk("sb.clear", 32'(ifc.hazard_o), 32'd0);
      ifc.lsu_valid_i = 1'b0;
      ifc.rs1_q_i = 5'd0; ifc.rs2_q_i = 5'd9;
      ifc.lsu_issue_i = 1'b1; ifc.lsu_issue_rd_i = 5'd9;
      step();
      chk("sb.rs2", 32'(ifc.hazard_o), 32'd1);
      ifc.lsu_issue_rd_i = 5'd0; ifc.rs2_q_i = 5'd0;
      step();
      chk("sb.x0", 32'(ifc.hazard_o), 32'd0);
`else
      chk("sb.off.rs1", 32'(ifc.hazard_o), 32'd0);
      ifc.lsu_issue_i = 1'b1; ifc.lsu_issue_rd_i = 5'd9; ifc.rs2_q_i = 5'd9;
      step();
      chk("sb.off.rs2", 32'(ifc.hazard_o), 32'd0);
`endif
      idle();
      step();

      // Reset while skid is FULL: buffered result must vanish.
      ifc.alu_valid_i = 1'b1; ifc.alu_rd_i = 5'd3; ifc.alu_data_i = 32'hAA;
      ifc.lsu_valid_i = 1'b1; ifc.lsu_rd_i = 5'd4; ifc.lsu_data_i = 32'h55;
      step();
      chk("rmid.full", 32'(ifc.alu_ready_o), 32'd0);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk_wr("rmid.in", 0, 5'd0, 32'h0, 4'h0);
      chk("rmid.in.ready",  32'(ifc.alu_ready_o), 32'd1);
      chk("rmid.in.hazard", 32'(ifc.hazard_o),    32'd0);
      step();
      #3 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk_wr($sformatf("rmid.post%0d", c), 0, 5'd0, 32'h0, 4'h0);
         chk($sformatf("rmid.post%0d.ready", c), 32'(ifc.alu_ready_o), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
